// File: rtl/wb_dbgmaster_pkg.sv
// Shared constants for the serial-to-Wishbone debug master: opcodes, status bytes
// and the command state encoding.
package wb_dbgmaster_pkg;

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] ST_OK    = 8'hA5;
   localparam logic [7:0] ST_ERR   = 8'hEE;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_BUS  = 3'd3,
      S_RESP = 3'd4
   } state_t;

   function automatic logic is_opcode(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/wb_dbgmaster.sv
// Byte-stream driven Wishbone initiator: decodes host commands from the UART,
// runs one single 32-bit cycle and streams the status or read data back.
module wb_dbgmaster
   import wb_dbgmaster_pkg::*;
#(
   parameter int unsigned timeout_cycles = 1024,
   parameter int unsigned rx_idle_cycles = 500000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_avail,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_busy,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   output logic        active
);

   localparam logic [15:0] TOUT_LAST = 16'(timeout_cycles - 32'd1);
   localparam logic [19:0] IDLE_LAST = 20'(rx_idle_cycles - 32'd1);

   state_t      state_r;
   logic [1:0]  byte_cnt_r;
   logic [19:0] idle_cnt_r;
   logic [15:0] tout_cnt_r;
   logic [31:0] resp_sr_r;
   logic [2:0]  tx_left_r;
   logic        tx_hold_r;

   // Only full 32-bit transfers are ever issued.
   assign wb_sel_o = 4'hF;

   // Command FSM with byte collection, bus cycle, timeouts and TX handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= S_IDLE;
         byte_cnt_r <= 2'd0;
         idle_cnt_r <= 20'd0;
         tout_cnt_r <= 16'd0;
         resp_sr_r  <= 32'd0;
         tx_left_r  <= 3'd0;
         tx_hold_r  <= 1'b0;
         wb_adr_o   <= 32'd0;
         wb_dat_o   <= 32'd0;
         wb_we_o    <= 1'b0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         tx_data    <= 8'd0;
         tx_wr      <= 1'b0;
         active     <= 1'b0;
      end else begin
         tx_wr <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (rx_avail && is_opcode(rx_data)) begin
                  wb_we_o    <= (rx_data == OP_WRITE);
                  byte_cnt_r <= 2'd0;
                  idle_cnt_r <= 20'd0;
                  state_r    <= S_ADDR;
                  active     <= 1'b1;
               end
            end
            S_ADDR, S_DATA: begin
               if (rx_avail) begin
                  idle_cnt_r <= 20'd0;
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (state_r == S_ADDR) begin
                     wb_adr_o <= {wb_adr_o[23:0], rx_data};
                  end else begin
                     wb_dat_o <= {wb_dat_o[23:0], rx_data};
                  end
                  if (byte_cnt_r == 2'd3) begin
                     if ((state_r == S_ADDR) && wb_we_o) begin
                        state_r <= S_DATA;
                     end else begin
                        state_r    <= S_BUS;
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        tout_cnt_r <= 16'd0;
                     end
                  end
               end else if (idle_cnt_r == IDLE_LAST) begin
                  // Host went quiet mid-command: drop it without a response.
                  idle_cnt_r <= 20'd0;
                  state_r    <= S_IDLE;
                  active     <= 1'b0;
               end else begin
                  idle_cnt_r <= idle_cnt_r + 20'd1;
               end
            end
            S_BUS: begin
               if (wb_err_i || wb_ack_i || (tout_cnt_r == TOUT_LAST)) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  tx_hold_r <= 1'b0;
                  state_r   <= S_RESP;
                  // Err beats a simultaneous ack; ack on the expiry cycle still succeeds.
                  if (wb_err_i || !wb_ack_i) begin
                     resp_sr_r <= {ST_ERR, 24'd0};
                     tx_left_r <= 3'd1;
                  end else if (wb_we_o) begin
                     resp_sr_r <= {ST_OK, 24'd0};
                     tx_left_r <= 3'd1;
                  end else begin
                     resp_sr_r <= wb_dat_i;
                     tx_left_r <= 3'd4;
                  end
               end else begin
                  tout_cnt_r <= tout_cnt_r + 16'd1;
               end
            end
            S_RESP: begin
               // After each pulse skip one cycle so a late-rising tx_busy is seen.
               if (tx_wr) begin
                  tx_hold_r <= 1'b1;
               end else if (tx_hold_r) begin
                  tx_hold_r <= 1'b0;
               end else if (tx_left_r == 3'd0) begin
                  state_r <= S_IDLE;
                  active  <= 1'b0;
               end else if (!tx_busy) begin
                  tx_data   <= resp_sr_r[31:24];
                  tx_wr     <= 1'b1;
                  resp_sr_r <= {resp_sr_r[23:0], 8'h00};
                  tx_left_r <= tx_left_r - 3'd1;
               end
            end
            default: begin
               state_r  <= S_IDLE;
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
               active   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_dbgmaster.sv
// Directed plus randomized bench for wb_dbgmaster with a behavioural slave,
// a UART transmitter model and a byte-level response model.
module tb_wb_dbgmaster;

   localparam int IDLE_CYC = 300;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_avail;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, active;

   wb_dbgmaster #(.timeout_cycles(1024), .rx_idle_cycles(IDLE_CYC)) dut (
      .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_avail(rx_avail),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .active(active)
   );

   always #5 clk = ~clk;

   typedef logic [7:0] bq_t[$];

   int total = 0;
   int bad = 0;

   // Slave behaviour: mode 0 ack, 1 ack+err, 2 silent, 3 err only.
   int          s_mode = 0;
   int          s_delay = 0;
   logic [31:0] s_rdata = 32'd0;

   int          txn_cnt = 0;
   int          cyc_len = 0;
   int          proto_err = 0;
   int          s_cnt = 0;
   bit          in_txn = 1'b0;
   logic [31:0] cap_adr, cap_dat;
   logic        cap_we;
   logic [3:0]  cap_sel;

   logic [7:0]  tx_log[$];
   int          busy_left = 0;

   // Wishbone slave model, acting on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         wb_dat_i = 32'd0;
         in_txn   = 1'b0;
      end else if (wb_cyc_o) begin
         if (!in_txn) begin
            in_txn  = 1'b1;
            txn_cnt = txn_cnt + 1;
            cap_adr = wb_adr_o;
            cap_dat = wb_dat_o;
            cap_we  = wb_we_o;
            cap_sel = wb_sel_o;
            cyc_len = 0;
            s_cnt   = 0;
         end
         cyc_len = cyc_len + 1;
         if (wb_stb_o !== 1'b1 || wb_we_o !== cap_we || wb_adr_o !== cap_adr) proto_err = proto_err + 1;
         if (s_mode != 2 && s_cnt == s_delay) begin
            wb_ack_i = (s_mode == 0 || s_mode == 1);
            wb_err_i = (s_mode == 1 || s_mode == 3);
            wb_dat_i = s_rdata;
         end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
         end
         s_cnt = s_cnt + 1;
      end else begin
         in_txn   = 1'b0;
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         if (wb_stb_o !== 1'b0) proto_err = proto_err + 1;
      end
   end

   // UART transmitter model: random busy time after each accepted byte.
   always @(negedge clk) begin
      if (!reset_n) begin
         busy_left = 0;
      end else if (tx_wr) begin
         if (busy_left != 0 || wb_cyc_o) proto_err = proto_err + 1;
         tx_log.push_back(tx_data);
         busy_left = $urandom_range(1, 4);
      end else if (busy_left != 0) begin
         busy_left = busy_left - 1;
      end
      tx_busy = (busy_left != 0);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Expected response bytes from the protocol rules.
   function automatic bq_t model_resp(input bit we, input int mode, input logic [31:0] rdata);
      bq_t q;
      if (mode != 0) q.push_back(8'hEE);
      else if (we) q.push_back(8'hA5);
      else for (int k = 3; k >= 0; k--) q.push_back(8'((rdata >> (8 * k)) & 32'hFF));
      return q;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_avail = 1'b1;
      @(negedge clk);
      rx_avail = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   task automatic send_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat);
      send_byte(we ? 8'h01 : 8'h02);
      for (int k = 3; k >= 0; k--) send_byte(8'((adr >> (8 * k)) & 32'hFF));
      if (we) for (int k = 3; k >= 0; k--) send_byte(8'((dat >> (8 * k)) & 32'hFF));
   endtask

   task automatic run_cmd(input string tag, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input int mode, input int dly,
                          input logic [31:0] rdata, input int strays);
      bq_t exp;
      int  base_tx, base_txn;
      bit  done;
      exp      = model_resp(we, mode, rdata);
      s_mode   = mode;
      s_delay  = dly;
      s_rdata  = rdata;
      base_tx  = tx_log.size();
      base_txn = txn_cnt;
      send_cmd(we, adr, dat);
      for (int k = 0; k < strays; k++) send_byte((k % 2 == 0) ? 8'h02 : 8'h01);
      done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         @(negedge clk);
         if (active == 1'b0 && tx_log.size() >= base_tx + exp.size()) done = 1'b1;
      end
      chk({tag, "_done"}, done, 1'b1);
      repeat (3) @(negedge clk);
      chk({tag, "_txn"}, txn_cnt - base_txn, 1);
      chk({tag, "_adr"}, cap_adr, adr);
      chk({tag, "_we"}, cap_we, we);
      chk({tag, "_sel"}, cap_sel, 4'hF);
      if (we) chk({tag, "_dat"}, cap_dat, dat);
      if (mode == 2) chk({tag, "_cyclen"}, cyc_len, 1024);
      chk({tag, "_nbytes"}, tx_log.size() - base_tx, exp.size());
      for (int k = 0; k < exp.size() && base_tx + k < tx_log.size(); k++)
         chk($sformatf("%s_byte%0d", tag, k), tx_log[base_tx + k], exp[k]);
      chk({tag, "_proto"}, proto_err, 0);
      chk({tag, "_idle"}, active, 1'b0);
   endtask

   initial begin
      int  base_txn, base_tx;
      bit  we;
      int  mode;
      reset_n  = 1'b0;
      rx_avail = 1'b0;
      rx_data  = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_cyc", wb_cyc_o, 1'b0);
      chk("rst_stb", wb_stb_o, 1'b0);
      chk("rst_we", wb_we_o, 1'b0);
      chk("rst_txwr", tx_wr, 1'b0);
      chk("rst_active", active, 1'b0);
      chk("rst_adr", wb_adr_o, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_txdata", tx_data, 8'd0);
      chk("rst_sel", wb_sel_o, 4'hF);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_cmd("write", 1'b1, 32'h0000_7002, 32'h0000_0055, 0, 2, 32'd0, 0);
      run_cmd("read", 1'b0, 32'h0000_0010, 32'd0, 0, 1, 32'hDEAD_BEEF, 0);
      run_cmd("tout", 1'b0, 32'h0000_0020, 32'd0, 2, 0, 32'd0, 0);
      run_cmd("errack", 1'b0, 32'h0000_0030, 32'd0, 1, 20, 32'h1234_5678, 2);

      for (int n = 0; n < 8; n++) begin
         we   = 1'($urandom_range(0, 1));
         mode = ($urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 1);
         run_cmd($sformatf("rnd%0d", n), we, $urandom, $urandom, mode,
                 $urandom_range(0, 6), $urandom, 0);
      end

      // Stalled partial command, then an unknown opcode.
      base_txn = txn_cnt;
      base_tx  = tx_log.size();
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h00);
      chk("stall_busy", active, 1'b1);
      repeat (IDLE_CYC + 20) @(negedge clk);
      chk("stall_idle", active, 1'b0);
      chk("stall_txn", txn_cnt - base_txn, 0);
      send_byte(8'h7F);
      repeat (3) @(negedge clk);
      chk("badop_idle", active, 1'b0);
      chk("badop_txn", txn_cnt - base_txn, 0);
      chk("stall_tx", tx_log.size() - base_tx, 0);
      run_cmd("after_stall", 1'b0, 32'hCAFE_0004, 32'd0, 0, 3, 32'h0BAD_F00D, 0);

      // Asynchronous reset while a cycle is outstanding.
      s_mode  = 2;
      base_tx = tx_log.size();
      send_cmd(1'b0, 32'h0000_0040, 32'd0);
      for (int i = 0; i < 40 && !wb_cyc_o; i++) @(negedge clk);
      chk("rst_mid_cyc_seen", wb_cyc_o, 1'b1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_cyc", wb_cyc_o, 1'b0);
      chk("rst_mid_stb", wb_stb_o, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_mid_active", active, 1'b0);
      chk("rst_mid_tx", tx_log.size() - base_tx, 0);
      run_cmd("after_rst", 1'b1, 32'h8000_0000, 32'hA5A5_0F0F, 0, 0, 32'd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
